// File: rtl/alarm.sv
// Home-security alarm decision block.
// Raises ALARM on a panic request (PANIC is active-low), or when the system is
// armed, the occupant is not exiting, and any of window/door/garage is open.
// Every input goes through its own SYNC_STAGES-deep synchroniser and ALARM is
// registered, so an input change reaches ALARM SYNC_STAGES+1 cycles later.
// Optional feature macro: ALARM_LATCH_EN. When it is defined, a triggered alarm
// stays on until the system is disarmed or reset.
module alarm #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic PANIC,
   input  logic ENABLE,
   input  logic EXITING,
   input  logic WINDOW,
   input  logic DOOR,
   input  logic GARAGE,
   output logic ALARM
);

   logic [SYNC_STAGES-1:0] sync_p;
   logic [SYNC_STAGES-1:0] sync_e;
   logic [SYNC_STAGES-1:0] sync_x;
   logic [SYNC_STAGES-1:0] sync_w;
   logic [SYNC_STAGES-1:0] sync_d;
   logic [SYNC_STAGES-1:0] sync_g;

   logic p;
   logic e;
   logic x;
   logic w;
   logic d;
   logic g;
   logic secure;
   logic alarm_next;

   // Synchroniser chains; the panic chain resets to its idle level (1).
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_p <= '1;
         sync_e <= '0;
         sync_x <= '0;
         sync_w <= '0;
         sync_d <= '0;
         sync_g <= '0;
      end else begin
         sync_p <= {sync_p[SYNC_STAGES-2:0], PANIC};
         sync_e <= {sync_e[SYNC_STAGES-2:0], ENABLE};
         sync_x <= {sync_x[SYNC_STAGES-2:0], EXITING};
         sync_w <= {sync_w[SYNC_STAGES-2:0], WINDOW};
         sync_d <= {sync_d[SYNC_STAGES-2:0], DOOR};
         sync_g <= {sync_g[SYNC_STAGES-2:0], GARAGE};
      end
   end

   assign p = sync_p[SYNC_STAGES-1];
   assign e = sync_e[SYNC_STAGES-1];
   assign x = sync_x[SYNC_STAGES-1];
   assign w = sync_w[SYNC_STAGES-1];
   assign d = sync_d[SYNC_STAGES-1];
   assign g = sync_g[SYNC_STAGES-1];

   // All openings closed.
   assign secure = w & d & g;

   // Panic wins outright; otherwise the alarm needs armed, not exiting, something open.
   assign alarm_next = ~p | (e & ~x & ~secure);

`ifdef ALARM_LATCH_EN
   logic flag;
   logic flag_next;

   // Sticky flag: disarming without panic clears it, any alarm condition sets it.
   always_comb begin
      flag_next = flag;
      if (~e & p) begin
         flag_next = 1'b0;
      end else if (alarm_next) begin
         flag_next = 1'b1;
      end
   end

   // Flag register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         flag <= 1'b0;
      end else begin
         flag <= flag_next;
      end
   end

   // Registered output, using the post-update flag so disarming silences the siren
   // on the same edge the clear takes effect.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ALARM <= 1'b0;
      end else begin
         ALARM <= alarm_next | flag_next;
      end
   end
`else
   // Registered output that follows the alarm condition directly.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ALARM <= 1'b0;
      end else begin
         ALARM <= alarm_next;
      end
   end
`endif

endmodule

// File: tb/tb_alarm.sv
// Self-checking bench for alarm: every driven input vector pushes its expected
// ALARM value to a queue, and the value is popped and compared three cycles later
// when the DUT produces it. Honours ALARM_LATCH_EN in its reference model.
module tb_alarm;

   logic CLK = 1'b0;
   logic RST;
   logic PANIC;
   logic ENABLE;
   logic EXITING;
   logic WINDOW;
   logic DOOR;
   logic GARAGE;
   logic ALARM;

   int checks = 0;
   int failures = 0;

   bit exp_q[$];
   bit model_flag;
   logic [5:0] cur_vec;

   alarm #(.SYNC_STAGES(2)) dut (
      .CLK(CLK),
      .RST(RST),
      .PANIC(PANIC),
      .ENABLE(ENABLE),
      .EXITING(EXITING),
      .WINDOW(WINDOW),
      .DOOR(DOOR),
      .GARAGE(GARAGE),
      .ALARM(ALARM)
   );

   // 100 MHz clock.
   always #5 CLK = ~CLK;

   // Reference model: vector is {PANIC,ENABLE,EXITING,WINDOW,DOOR,GARAGE}.
   function automatic bit model(input logic [5:0] v);
      bit p, e, x, sec, an;
      p   = v[5];
      e   = v[4];
      x   = v[3];
      sec = v[2] & v[1] & v[0];
      an  = ~p | (e & ~x & ~sec);
`ifdef ALARM_LATCH_EN
      if (~e & p) model_flag = 1'b0;
      else if (an) model_flag = 1'b1;
      return model_flag;
`else
      return an;
`endif
   endfunction

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: ALARM=%b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive a vector onto the inputs and record what ALARM must show for it.
   task automatic drive(input logic [5:0] v);
      {PANIC, ENABLE, EXITING, WINDOW, DOOR, GARAGE} = v;
      exp_q.push_back(model(v));
   endtask

   // One clock: compare the output due now, then drive the current vector.
   task automatic stepCycle(input string tag);
      bit e;
      @(posedge CLK);
      #1;
      if (exp_q.size() == 0) begin
         checkOutput({tag, "_empty_queue"}, ALARM, 1'bx);
      end else begin
         e = exp_q.pop_front();
         checkOutput(tag, ALARM, e);
      end
      drive(cur_vec);
   endtask

   // Hold a vector for n cycles, checking ALARM every cycle.
   task automatic applyStimulus(input string tag, input logic [5:0] v, input int n);
      cur_vec = v;
      repeat (n) stepCycle(tag);
   endtask

   // Reset with inputs held at v, then release; the synchronisers still hold
   // reset values for the first two output cycles, which must be 0.
   task automatic doReset(input logic [5:0] v);
      RST = 1'b1;
      {PANIC, ENABLE, EXITING, WINDOW, DOOR, GARAGE} = v;
      exp_q.delete();
      model_flag = 1'b0;
      @(posedge CLK);
      #1;
      checkOutput("reset_state", ALARM, 1'b0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b0);
      cur_vec = v;
      drive(v);
   endtask

   initial begin
      RST = 1'b1;
      {PANIC, ENABLE, EXITING, WINDOW, DOOR, GARAGE} = 6'b100000;
      model_flag = 1'b0;
      cur_vec = 6'b100000;
      #2;
      checkOutput("reset_async", ALARM, 1'b0);

      // Armed, exiting, door open: no alarm.
      doReset(6'b111101);
      applyStimulus("case1_exiting", 6'b111101, 6);
      // Stop exiting: alarm exactly three cycles later.
      applyStimulus("case2_armed_open", 6'b110101, 6);
      // Close the door: non-latching clears, latching holds.
      applyStimulus("case3_all_closed", 6'b110111, 6);
      // Open the window: alarm again.
      applyStimulus("case4_window_open", 6'b110011, 6);
      checkOutput("case4_alarm_on", ALARM, 1'b1);

      // Reset in the middle of a clock cycle must clear ALARM at once.
      @(posedge CLK);
      #3;
      RST = 1'b1;
      #1;
      checkOutput("rst_mid_cycle", ALARM, 1'b0);

      // Panic overrides everything, then release panic.
      doReset(6'b000111);
      applyStimulus("panic_on", 6'b000111, 6);
      applyStimulus("panic_off", 6'b100111, 6);

      // Disarmed with everything open: no alarm; then a one-cycle panic pulse.
      doReset(6'b100000);
      applyStimulus("disarmed_open", 6'b100000, 6);
      applyStimulus("panic_pulse", 6'b000000, 1);
      applyStimulus("after_pulse", 6'b100000, 6);

      // Latch behaviour check: trigger, close openings, then disarm.
      doReset(6'b110110);
      applyStimulus("latch_trigger", 6'b110110, 5);
      applyStimulus("latch_close", 6'b110111, 5);
      applyStimulus("latch_disarm", 6'b100111, 5);

      // Random vectors held for 1..4 cycles each.
      for (int i = 0; i < 40; i++) begin
         applyStimulus("random", 6'($urandom_range(0, 63)), int'($urandom_range(1, 4)));
      end
      applyStimulus("drain", cur_vec, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   // Hard stop in case something stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
